// File: rtl/parking_code_entry_if.sv
// Keypad bundle between the button front-end and the code entry block.
// The master side drives the raw buttons; the slave side returns the
// assembled code and the status signals.
interface parking_code_entry_if;
  logic       btn_zero;
  logic       btn_one;
  logic       btn_enter;
  logic       btn_clear;
  logic [3:0] code_out;
  logic       code_valid;
  logic [2:0] digit_count;
  logic       entry_error;

  modport master (
    output btn_zero, btn_one, btn_enter, btn_clear,
    input  code_out, code_valid, digit_count, entry_error
  );

  modport slave (
    input  btn_zero, btn_one, btn_enter, btn_clear,
    output code_out, code_valid, digit_count, entry_error
  );
endinterface

// File: rtl/parking_code_entry.sv
// Keypad front-end for the parking gate controller.
// Four raw buttons are synchronized and debounced, press edges are
// prioritised (clear > enter > one > zero), and a 4-bit code is assembled
// MSB-first. A completed code is shown on code_out for a fixed hold window;
// code_out reads 0000 otherwise so a partial code never reaches the gate.
module parking_code_entry #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd16,
  parameter logic [15:0] KEY_TIMEOUT     = 16'd10000,
  parameter logic [15:0] HOLD_CYCLES     = 16'd8
) (
  input  logic                  clock,
  input  logic                  reset,
  parking_code_entry_if.slave   kp
);

  // Terminal counts; a zero parameter is treated as one so nothing underflows.
  localparam logic [15:0] DEB_LAST  = (DEBOUNCE_CYCLES == 16'd0) ? 16'd0 : DEBOUNCE_CYCLES - 16'd1;
  localparam logic [15:0] TMO_LAST  = (KEY_TIMEOUT     == 16'd0) ? 16'd0 : KEY_TIMEOUT - 16'd1;
  localparam logic [15:0] HOLD_LAST = (HOLD_CYCLES     == 16'd0) ? 16'd0 : HOLD_CYCLES - 16'd1;
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  // Button index: 0 = zero, 1 = one, 2 = enter, 3 = clear.
  localparam int unsigned NBTN = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PRESENT = 2'd2
  } state_e;

  // Button conditioning state.
  logic [3:0]  raw_s;
  logic [3:0]  sync1_q, sync1_d;
  logic [3:0]  sync2_q, sync2_d;
  logic [3:0]  level_q, level_d;
  logic [15:0] stab_q [NBTN];
  logic [15:0] stab_d [NBTN];
  logic [3:0]  press_s;

  // Entry state.
  state_e      state_q, state_d;
  logic [3:0]  shift_q, shift_d;
  logic [2:0]  count_q, count_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] hold_q,  hold_d;
  logic [3:0]  code_q,  code_d;
  logic        valid_q, valid_d;
  logic        err_q,   err_d;

  // Prioritised events.
  logic ev_clear_s;
  logic ev_enter_s;
  logic ev_one_s;
  logic ev_zero_s;
  logic ev_digit_s;

  assign raw_s = {kp.btn_clear, kp.btn_enter, kp.btn_one, kp.btn_zero};

  // Synchronizer chain, stability counters and debounced levels.
  always_comb begin
    sync1_d = raw_s;
    sync2_d = sync1_q;
    level_d = level_q;
    press_s = 4'b0000;
    for (int i = 0; i < NBTN; i++) begin
      stab_d[i] = 16'd0;
      if (sync2_q[i] != level_q[i]) begin
        if (stab_q[i] >= DEB_LAST) begin
          // Stable long enough: adopt the new level; a rising level is a press.
          level_d[i] = sync2_q[i];
          press_s[i] = sync2_q[i];
          stab_d[i]  = 16'd0;
        end else begin
          stab_d[i] = stab_q[i] + 16'd1;
        end
      end else begin
        stab_d[i] = 16'd0;
      end
    end
  end

  // Conditioning registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
      level_q <= 4'b0000;
      for (int i = 0; i < NBTN; i++) begin
        stab_q[i] <= 16'd0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      for (int i = 0; i < NBTN; i++) begin
        stab_q[i] <= stab_d[i];
      end
    end
  end

  // Same-cycle presses: only the highest-priority event survives.
  always_comb begin
    ev_clear_s = press_s[3];
    ev_enter_s = press_s[2] & ~press_s[3];
    ev_one_s   = press_s[1] & ~press_s[2] & ~press_s[3];
    ev_zero_s  = press_s[0] & ~press_s[1] & ~press_s[2] & ~press_s[3];
    ev_digit_s = ev_one_s | ev_zero_s;
  end

  // Entry FSM: next state, shift register, timers and registered outputs.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    timer_d = timer_q;
    hold_d  = hold_q;
    code_d  = code_q;
    valid_d = valid_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        code_d  = 4'b0000;
        valid_d = 1'b0;
        if (ev_digit_s) begin
          shift_d = {shift_q[2:0], ev_one_s};
          count_d = 3'd1;
          timer_d = 16'd0;
          state_d = ST_COLLECT;
        end else if (ev_enter_s) begin
          err_d = 1'b1;
        end else begin
          // Clear or no event: nothing to do while idle.
          state_d = ST_IDLE;
        end
      end

      ST_COLLECT: begin
        if (ev_clear_s) begin
          state_d = ST_IDLE;
          shift_d = 4'b0000;
          count_d = 3'd0;
        end else if (ev_enter_s) begin
          if (count_q == 3'd4) begin
            state_d = ST_PRESENT;
            code_d  = shift_q;
            valid_d = 1'b1;
            hold_d  = 16'd0;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
            shift_d = 4'b0000;
            count_d = 3'd0;
          end
        end else if (ev_digit_s) begin
          timer_d = 16'd0;
          if (count_q < 3'd4) begin
            shift_d = {shift_q[2:0], ev_one_s};
            count_d = count_q + 3'd1;
          end else begin
            // Code already full: reject the extra digit but keep what was typed.
            err_d = 1'b1;
          end
        end else if (timer_q >= TMO_LAST) begin
          // Entry abandoned silently.
          state_d = ST_IDLE;
          shift_d = 4'b0000;
          count_d = 3'd0;
        end else if (timer_q != CNT_MAX) begin
          timer_d = timer_q + 16'd1;
        end else begin
          timer_d = timer_q;
        end
      end

      ST_PRESENT: begin
        // Digits and enter are ignored here; only clear or expiry end the window.
        if (ev_clear_s || (hold_q >= HOLD_LAST)) begin
          state_d = ST_IDLE;
          code_d  = 4'b0000;
          valid_d = 1'b0;
          count_d = 3'd0;
          shift_d = 4'b0000;
        end else if (hold_q != CNT_MAX) begin
          hold_d = hold_q + 16'd1;
        end else begin
          hold_d = hold_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
        shift_d = 4'b0000;
        count_d = 3'd0;
        timer_d = 16'd0;
        hold_d  = 16'd0;
        code_d  = 4'b0000;
        valid_d = 1'b0;
      end
    endcase
  end

  // Entry FSM registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= 4'b0000;
      count_q <= 3'd0;
      timer_q <= 16'd0;
      hold_q  <= 16'd0;
      code_q  <= 4'b0000;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      timer_q <= timer_d;
      hold_q  <= hold_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign kp.code_out    = code_q;
  assign kp.code_valid  = valid_q;
  assign kp.digit_count = count_q;
  assign kp.entry_error = err_q;

endmodule

// File: tb/tb_parking_code_entry.sv
// Directed bench for parking_code_entry with short debounce/timeout values.
module tb_parking_code_entry;

  logic clock;
  logic reset;

  parking_code_entry_if kp();

  parking_code_entry #(
    .DEBOUNCE_CYCLES(16'd4),
    .KEY_TIMEOUT    (16'd50),
    .HOLD_CYCLES    (16'd8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .kp   (kp)
  );

  int checks = 0;
  int errors = 0;

  // Monitor counters, sampled on the falling edge; only ever increase.
  int         valid_cycles = 0;
  int         leak_cycles  = 0;
  int         err_pulses   = 0;
  int         err_long     = 0;
  logic       prev_err     = 1'b0;
  logic [3:0] seen_code    = 4'd0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observe outputs between active edges.
  always @(negedge clock) begin
    if (kp.code_valid === 1'b1) begin
      valid_cycles <= valid_cycles + 1;
      seen_code    <= kp.code_out;
    end
    if (kp.code_valid !== 1'b1 && kp.code_out !== 4'd0) leak_cycles <= leak_cycles + 1;
    if (kp.entry_error === 1'b1) err_pulses <= err_pulses + 1;
    if (kp.entry_error === 1'b1 && prev_err === 1'b1) err_long <= err_long + 1;
    prev_err <= kp.entry_error;
  end

  // Hold one button (0 zero, 1 one, 2 enter, 3 clear) for 12 cycles, release for 12.
  task automatic press(input int key);
    @(posedge clock); #1;
    case (key)
      0: kp.btn_zero  = 1'b1;
      1: kp.btn_one   = 1'b1;
      2: kp.btn_enter = 1'b1;
      default: kp.btn_clear = 1'b1;
    endcase
    repeat (12) @(posedge clock);
    #1;
    kp.btn_zero = 1'b0; kp.btn_one = 1'b0; kp.btn_enter = 1'b0; kp.btn_clear = 1'b0;
    repeat (12) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    kp.btn_zero = 1'b0; kp.btn_one = 1'b0; kp.btn_enter = 1'b0; kp.btn_clear = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (kp.code_out !== 4'd0) begin errors++; $display("FAIL reset_code: got %b expected 0000", kp.code_out); end
    checks++; if (kp.code_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", kp.code_valid); end
    checks++; if (kp.digit_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", kp.digit_count); end
    checks++; if (kp.entry_error !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", kp.entry_error); end
    #3 reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic test_debounce();
    @(posedge clock); #1;
    kp.btn_one = 1'b1;
    repeat (3) @(posedge clock);
    #1 kp.btn_one = 1'b0;
    repeat (15) @(posedge clock);
    #1;
    checks++; if (kp.digit_count !== 3'd0) begin errors++; $display("FAIL debounce_glitch: digit_count %0d expected 0", kp.digit_count); end
    press(1);
    checks++; if (kp.digit_count !== 3'd1) begin errors++; $display("FAIL debounce_press: digit_count %0d expected 1", kp.digit_count); end
    press(3);
    checks++; if (kp.digit_count !== 3'd0) begin errors++; $display("FAIL debounce_clear: digit_count %0d expected 0", kp.digit_count); end
  endtask

  task automatic test_code_1101();
    int v0, e0, l0;
    v0 = valid_cycles; e0 = err_pulses; l0 = leak_cycles;
    press(1);
    checks++; if (kp.digit_count !== 3'd1) begin errors++; $display("FAIL c1101_cnt1: got %0d expected 1", kp.digit_count); end
    press(1);
    checks++; if (kp.digit_count !== 3'd2) begin errors++; $display("FAIL c1101_cnt2: got %0d expected 2", kp.digit_count); end
    press(0);
    press(1);
    checks++; if (kp.digit_count !== 3'd4) begin errors++; $display("FAIL c1101_cnt4: got %0d expected 4", kp.digit_count); end
    checks++; if (kp.code_out !== 4'd0) begin errors++; $display("FAIL c1101_collect_code: got %b expected 0000", kp.code_out); end
    press(2);
    checks++; if (seen_code !== 4'b1101) begin errors++; $display("FAIL c1101_code: got %b expected 1101", seen_code); end
    checks++; if (valid_cycles - v0 != 8) begin errors++; $display("FAIL c1101_hold: got %0d expected 8", valid_cycles - v0); end
    checks++; if (kp.code_out !== 4'd0 || kp.code_valid !== 1'b0) begin errors++; $display("FAIL c1101_after: code %b valid %b expected 0000 0", kp.code_out, kp.code_valid); end
    checks++; if (kp.digit_count !== 3'd0) begin errors++; $display("FAIL c1101_after_cnt: got %0d expected 0", kp.digit_count); end
    checks++; if (err_pulses != e0) begin errors++; $display("FAIL c1101_err: got %0d expected %0d", err_pulses, e0); end
    checks++; if (leak_cycles != l0) begin errors++; $display("FAIL c1101_leak: got %0d expected %0d", leak_cycles, l0); end
  endtask

  task automatic test_short_enter();
    int v0, e0, x0;
    v0 = valid_cycles; e0 = err_pulses; x0 = err_long;
    press(1);
    press(0);
    press(2);
    checks++; if (err_pulses - e0 != 1) begin errors++; $display("FAIL short_err: got %0d expected 1", err_pulses - e0); end
    checks++; if (err_long != x0) begin errors++; $display("FAIL short_err_width: got %0d expected %0d", err_long, x0); end
    checks++; if (kp.digit_count !== 3'd0) begin errors++; $display("FAIL short_cnt: got %0d expected 0", kp.digit_count); end
    checks++; if (valid_cycles != v0) begin errors++; $display("FAIL short_valid: got %0d expected %0d", valid_cycles, v0); end
    press(2);
    checks++; if (err_pulses - e0 != 2) begin errors++; $display("FAIL idle_enter_err: got %0d expected 2", err_pulses - e0); end
    checks++; if (kp.digit_count !== 3'd0) begin errors++; $display("FAIL idle_enter_cnt: got %0d expected 0", kp.digit_count); end
  endtask

  task automatic test_fifth_digit();
    int v0, e0;
    v0 = valid_cycles; e0 = err_pulses;
    press(1); press(0); press(1); press(1);
    press(0);
    checks++; if (err_pulses - e0 != 1) begin errors++; $display("FAIL fifth_err: got %0d expected 1", err_pulses - e0); end
    checks++; if (kp.digit_count !== 3'd4) begin errors++; $display("FAIL fifth_cnt: got %0d expected 4", kp.digit_count); end
    press(2);
    checks++; if (seen_code !== 4'b1011) begin errors++; $display("FAIL fifth_code: got %b expected 1011", seen_code); end
    checks++; if (valid_cycles - v0 != 8) begin errors++; $display("FAIL fifth_hold: got %0d expected 8", valid_cycles - v0); end
    checks++; if (err_pulses - e0 != 1) begin errors++; $display("FAIL fifth_err_total: got %0d expected 1", err_pulses - e0); end
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_pulses;
    press(1);
    repeat (20) @(posedge clock);
    #1;
    checks++; if (kp.digit_count !== 3'd1) begin errors++; $display("FAIL timeout_early: got %0d expected 1", kp.digit_count); end
    repeat (22) @(posedge clock);
    #1;
    checks++; if (kp.digit_count !== 3'd0) begin errors++; $display("FAIL timeout_late: got %0d expected 0", kp.digit_count); end
    checks++; if (err_pulses != e0) begin errors++; $display("FAIL timeout_err: got %0d expected %0d", err_pulses, e0); end
  endtask

  task automatic test_clear_priority();
    int v0, e0;
    v0 = valid_cycles; e0 = err_pulses;
    press(0); press(1); press(1); press(0);
    @(posedge clock); #1;
    kp.btn_clear = 1'b1; kp.btn_enter = 1'b1;
    repeat (12) @(posedge clock);
    #1 kp.btn_clear = 1'b0; kp.btn_enter = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    checks++; if (kp.digit_count !== 3'd0) begin errors++; $display("FAIL prio_cnt: got %0d expected 0", kp.digit_count); end
    checks++; if (valid_cycles != v0) begin errors++; $display("FAIL prio_valid: got %0d expected %0d", valid_cycles, v0); end
    checks++; if (err_pulses != e0) begin errors++; $display("FAIL prio_err: got %0d expected %0d", err_pulses, e0); end
  endtask

  task automatic test_async_reset();
    int v0;
    press(1); press(0); press(1);
    checks++; if (kp.digit_count !== 3'd3) begin errors++; $display("FAIL rst_pre_cnt: got %0d expected 3", kp.digit_count); end
    #3 reset = 1'b1;
    #1;
    checks++; if (kp.digit_count !== 3'd0) begin errors++; $display("FAIL rst_collect_cnt: got %0d expected 0", kp.digit_count); end
    checks++; if (kp.code_out !== 4'd0 || kp.code_valid !== 1'b0 || kp.entry_error !== 1'b0) begin errors++; $display("FAIL rst_collect_out: code %b valid %b err %b expected 0", kp.code_out, kp.code_valid, kp.entry_error); end
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    press(1); press(1); press(1); press(1);
    @(posedge clock); #1;
    kp.btn_enter = 1'b1;
    repeat (9) @(posedge clock);
    #3;
    checks++; if (kp.code_valid !== 1'b1 || kp.code_out !== 4'b1111) begin errors++; $display("FAIL rst_present_pre: code %b valid %b expected 1111 1", kp.code_out, kp.code_valid); end
    reset = 1'b1;
    #1;
    checks++; if (kp.code_out !== 4'd0 || kp.code_valid !== 1'b0 || kp.digit_count !== 3'd0) begin errors++; $display("FAIL rst_present_out: code %b valid %b cnt %0d expected 0", kp.code_out, kp.code_valid, kp.digit_count); end
    kp.btn_enter = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    checks++; if (kp.code_valid !== 1'b0 || kp.entry_error !== 1'b0) begin errors++; $display("FAIL rst_release: valid %b err %b expected 0 0", kp.code_valid, kp.entry_error); end
    v0 = valid_cycles;
    press(0); press(1); press(1); press(0);
    press(2);
    checks++; if (seen_code !== 4'b0110) begin errors++; $display("FAIL rst_after_code: got %b expected 0110", seen_code); end
    checks++; if (valid_cycles - v0 != 8) begin errors++; $display("FAIL rst_after_hold: got %0d expected 8", valid_cycles - v0); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_code_1101();
    test_short_enter();
    test_fifth_digit();
    test_timeout();
    test_clear_priority();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
